// File: rtl/pipe_ctrl.sv
// pipe_ctrl: owns per-stage valid bits and derives every stage's latch enable.
// Build with PIPE_CTRL_PERF_EN defined to include the cycle/instret/flush counters.
module pipe_ctrl #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned IDX_W  = $clog2(STAGES)
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              F_FIRE,
  input  logic [STAGES-1:0] STALL_REQ,
  input  logic              REDIRECT,
  input  logic [IDX_W-1:0]  REDIRECT_STAGE,
  input  logic              REDIRECT_KILL,
  input  logic              DRAIN,
  output logic [STAGES-1:0] STAGE_V,
  output logic [STAGES-1:0] STAGE_LD,
  output logic              F_STALL,
  output logic              RETIRE,
  output logic              DRAINED,
  output logic [CNT_W-1:0]  CYCLE_CNT,
  output logic [CNT_W-1:0]  INSTRET_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_nx;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] adv_in;
  logic [31:0]       redir_k;
  logic              redir_ok;

  // Hold chain walks from the oldest stage down; a scalar carry keeps it acyclic.
  always_comb begin
    logic        h;
    int unsigned idx;
    h    = 1'b0;
    hold = '0;
    idx  = 0;
    for (int unsigned n = 0; n < STAGES; n++) begin
      idx       = STAGES - 1 - n;
      h         = v_q[idx] & (STALL_REQ[idx] | h);
      hold[idx] = h;
    end
  end

  // adv_in[i]: what stage i would capture if it loads this cycle.
  assign adv_in   = {v_q[STAGES-2:0] & ~hold[STAGES-2:0], F_FIRE & ~DRAIN};
  assign redir_k  = 32'(REDIRECT_STAGE);
  assign redir_ok = REDIRECT && (redir_k < STAGES);

  always_comb begin
    v_nx = (hold & v_q) | (~hold & adv_in);
    if (redir_ok) begin
      for (int unsigned j = 0; j < STAGES; j++) begin
        if (j < redir_k)
          v_nx[j] = 1'b0;
        else if (j == redir_k)
          v_nx[j] = v_q[j] & hold[j] & ~REDIRECT_KILL;
        else if (j == redir_k + 1)
          v_nx[j] = hold[j] ? v_q[j] : (adv_in[j] & ~REDIRECT_KILL);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) v_q <= '0;
    else          v_q <= v_nx;
  end

  assign STAGE_V  = v_q;
  assign STAGE_LD = ~hold;
  assign F_STALL  = hold[0] | DRAIN;
  assign RETIRE   = v_q[STAGES-1] & ~STALL_REQ[STAGES-1];
  assign DRAINED  = ~|v_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cycle_q   <= '0;
      instret_q <= '0;
      flush_q   <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (RETIRE)   instret_q <= instret_q + CNT_W'(1);
      if (redir_ok) flush_q   <= flush_q + CNT_W'(1);
    end
  end

  assign CYCLE_CNT   = cycle_q;
  assign INSTRET_CNT = instret_q;
  assign FLUSH_CNT   = flush_q;
`else
  assign CYCLE_CNT   = '0;
  assign INSTRET_CNT = '0;
  assign FLUSH_CNT   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan cases plus a randomized
// scoreboard run against a behavioural model of the valid-bit pipeline.
module tb_pipe_ctrl;
  localparam int S  = 5;
  localparam int CW = 4;
  localparam int IW = $clog2(S);

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          F_FIRE = 1'b0;
  logic [S-1:0]  STALL_REQ = '0;
  logic          REDIRECT = 1'b0;
  logic [IW-1:0] REDIRECT_STAGE = '0;
  logic          REDIRECT_KILL = 1'b0;
  logic          DRAIN = 1'b0;
  logic [S-1:0]  STAGE_V, STAGE_LD;
  logic          F_STALL, RETIRE, DRAINED;
  logic [CW-1:0] CYCLE_CNT, INSTRET_CNT, FLUSH_CNT;

  always #5 CLK = ~CLK;

  pipe_ctrl #(.STAGES(S), .CNT_W(CW), .IDX_W(IW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .F_FIRE(F_FIRE), .STALL_REQ(STALL_REQ),
    .REDIRECT(REDIRECT), .REDIRECT_STAGE(REDIRECT_STAGE), .REDIRECT_KILL(REDIRECT_KILL),
    .DRAIN(DRAIN), .STAGE_V(STAGE_V), .STAGE_LD(STAGE_LD), .F_STALL(F_STALL),
    .RETIRE(RETIRE), .DRAINED(DRAINED), .CYCLE_CNT(CYCLE_CNT),
    .INSTRET_CNT(INSTRET_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  typedef struct packed {
    logic [S-1:0]  v;
    logic [CW-1:0] cyc;
    logic [CW-1:0] inst;
    logic [CW-1:0] fl;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [S-1:0]  mv = '0;
  logic [CW-1:0] mcyc = '0, minst = '0, mfl = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt_exp(input logic [CW-1:0] m);
`ifdef PIPE_CTRL_PERF_EN
    return m;
`else
    return '0;
`endif
  endfunction

  // Drive one cycle's inputs, check combinational outputs, push the expected
  // post-edge state, then pop and compare it after the edge.
  task automatic cycle(input logic f, input logic [S-1:0] st, input logic rd,
                       input logic [IW-1:0] rk, input logic kill, input logic dr);
    logic [S:0]   h;
    logic [S-1:0] nv;
    logic [S-1:0] exp_ld;
    logic         p, ret, acc;
    int           k;
    exp_t         e;
    F_FIRE = f; STALL_REQ = st; REDIRECT = rd; REDIRECT_STAGE = rk;
    REDIRECT_KILL = kill; DRAIN = dr;
    #1;
    h[S] = 1'b0;
    for (int i = S - 1; i >= 0; i--) h[i] = mv[i] & (st[i] | h[i+1]);
    p = f & ~dr;
    for (int i = 0; i < S; i++) begin
      nv[i] = h[i] ? mv[i] : p;
      p     = mv[i] & ~h[i];
    end
    k   = int'(rk);
    acc = rd && (k < S);
    if (acc) begin
      for (int j = 0; j < k; j++) nv[j] = 1'b0;
      nv[k] = (h[k] && !kill) ? mv[k] : 1'b0;
      if (k + 1 < S) nv[k+1] = h[k+1] ? mv[k+1] : (mv[k] & ~h[k] & ~kill);
    end
    ret    = mv[S-1] & ~st[S-1];
    exp_ld = ~h[S-1:0];
    check_eq("stage_ld", STAGE_LD, exp_ld);
    check_eq("f_stall", F_STALL, h[0] | dr);
    check_eq("retire", RETIRE, ret);
    check_eq("drained", DRAINED, mv == '0);
    mcyc++;
    if (ret) minst++;
    if (acc) mfl++;
    mv     = nv;
    e.v    = nv;
    e.cyc  = mcyc;
    e.inst = minst;
    e.fl   = mfl;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check_eq("stage_v", STAGE_V, e.v);
      check_eq("cycle_cnt", CYCLE_CNT, cnt_exp(e.cyc));
      check_eq("instret_cnt", INSTRET_CNT, cnt_exp(e.inst));
      check_eq("flush_cnt", FLUSH_CNT, cnt_exp(e.fl));
    end
  endtask

  task automatic idle(input logic f);
    cycle(f, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Asserts reset between edges and checks the clear is immediate.
  task automatic do_reset();
    RESET_N = 1'b0; F_FIRE = 1'b0; STALL_REQ = '0; REDIRECT = 1'b0;
    REDIRECT_STAGE = '0; REDIRECT_KILL = 1'b0; DRAIN = 1'b0;
    #1;
    mv = '0; mcyc = '0; minst = '0; mfl = '0;
    sb.delete();
    check_eq("rst_v", STAGE_V, 0);
    check_eq("rst_ld", STAGE_LD, 5'b11111);
    check_eq("rst_retire", RETIRE, 0);
    check_eq("rst_drained", DRAINED, 1);
    check_eq("rst_cyc", CYCLE_CNT, 0);
    check_eq("rst_inst", INSTRET_CNT, 0);
    check_eq("rst_flush", FLUSH_CNT, 0);
    DRAIN = 1'b1;
    #1 check_eq("rst_fstall_drain", F_STALL, 1);
    DRAIN = 1'b0;
    #1 check_eq("rst_fstall", F_STALL, 0);
    @(posedge CLK);
    #1 RESET_N = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [S-1:0] fillv [5];
    fillv = '{5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
    @(posedge CLK);
    #1;
    do_reset();

    // Fill
    for (int i = 0; i < 5; i++) begin
      idle(1'b1);
      check_eq("fill_v", STAGE_V, fillv[i]);
    end
    check_eq("fill_retire", RETIRE, 1);

    // Backpressure on stage 2
    cycle(1'b1, 5'b00100, 1'b0, '0, 1'b0, 1'b0);
    check_eq("bp_v1", STAGE_V, 5'b10111);
    check_eq("bp_ld", STAGE_LD, 5'b11000);
    check_eq("bp_fstall", F_STALL, 1);
    cycle(1'b1, 5'b00100, 1'b0, '0, 1'b0, 1'b0);
    check_eq("bp_v2", STAGE_V, 5'b00111);
    check_eq("bp_retire_end", RETIRE, 0);

    // Bubble collapse
    do_reset();
    idle(1'b1); idle(1'b0); idle(1'b1);
    check_eq("bub_v0", STAGE_V, 5'b00101);
    cycle(1'b0, 5'b01000, 1'b0, '0, 1'b0, 1'b0);
    check_eq("bub_v1", STAGE_V, 5'b01010);

    // Redirect, redirect+kill, out-of-range redirect
    do_reset();
    for (int i = 0; i < 5; i++) idle(1'b1);
    cycle(1'b1, '0, 1'b1, 3'd3, 1'b0, 1'b0);
    check_eq("redir_v", STAGE_V, 5'b10000);
    check_eq("redir_flush", FLUSH_CNT, cnt_exp(4'd1));
    do_reset();
    for (int i = 0; i < 5; i++) idle(1'b1);
    cycle(1'b1, '0, 1'b1, 3'd3, 1'b1, 1'b0);
    check_eq("kill_v", STAGE_V, 5'b00000);
    check_eq("kill_flush", FLUSH_CNT, cnt_exp(4'd1));
    do_reset();
    for (int i = 0; i < 5; i++) idle(1'b1);
    cycle(1'b1, '0, 1'b1, 3'd6, 1'b1, 1'b0);
    check_eq("oor_v", STAGE_V, 5'b11111);
    check_eq("oor_flush", FLUSH_CNT, 0);

    // Drain, then asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) cycle(1'b1, '0, 1'b0, '0, 1'b0, 1'b1);
    check_eq("drain_drained", DRAINED, 1);
    check_eq("drain_fstall", F_STALL, 1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    #2;
    do_reset();

    // Counter wrap: 18 cycles, 3 retires
    for (int i = 0; i < 3; i++) idle(1'b1);
    for (int i = 0; i < 15; i++) idle(1'b0);
    check_eq("cnt_cycle_wrap", CYCLE_CNT, cnt_exp(4'd2));
    check_eq("cnt_instret", INSTRET_CNT, cnt_exp(4'd3));

    // Randomized scoreboard run
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom & $urandom;
      cycle(($urandom % 4) != 0, r[S-1:0], ($urandom % 6) == 0,
            IW'($urandom % 8), $urandom % 2 == 1, ($urandom % 10) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
